// File: rtl/mini_cpu_pkg.sv
// mini_cpu_pkg: shared widths, requester ids and helpers for the register-file write path.
package mini_cpu_pkg;

    localparam int NREQ = 3;
    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int PW   = $clog2(NREQ);
    localparam int CW   = 8;

    typedef enum logic [PW-1:0] {
        REQ_ALU = 2'd0,
        REQ_LD  = 2'd1,
        REQ_DBG = 2'd2
    } req_id_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mini_rr_pick.sv
// mini_rr_pick: combinational round-robin picker; first requester at or after ptr wins.
module mini_rr_pick
    import mini_cpu_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mini_rf_wr_arbiter.sv
// mini_rf_wr_arbiter: round-robin arbiter for the register file write port with registered strobe.
// Define MINI_RF_ARB_PERF_EN to add saturating grant (gcnt_o) and contention (ccnt_o) counters.
module mini_rf_wr_arbiter
    import mini_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] data_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
`ifdef MINI_RF_ARB_PERF_EN
    output logic [NREQ*CW-1:0] gcnt_o,
    output logic [CW-1:0]     ccnt_o,
`endif
    output logic              busy_o
);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   k;
    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic            granted;

    mini_rr_pick u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .gnt   (pick),
        .valid (pick_valid)
    );

    // freeze and reset suppress the grant but leave the requests visible on busy_o
    assign gnt_o   = (freeze_i || rst) ? '0 : pick;
    assign granted = pick_valid && !freeze_i && !rst;
    assign busy_o  = |(req_i & ~gnt_o);

    always_comb begin
        k = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt_o[i]) k = PW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (granted) begin
            ptr      <= (k == PW'(NREQ - 1)) ? '0 : k + 1'b1;
            rf_we    <= 1'b1;
            rf_waddr <= addr_i[k*AW +: AW];
            rf_wdata <= data_i[k*DW +: DW];
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef MINI_RF_ARB_PERF_EN
    logic [CW-1:0] gcnt [NREQ];
    logic [CW-1:0] ccnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) gcnt[i] <= '0;
            ccnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt_o[i]) gcnt[i] <= sat_inc(gcnt[i]);
            if ($countones(req_i) >= 2) ccnt <= sat_inc(ccnt);
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign gcnt_o[g*CW +: CW] = gcnt[g];
    end
    assign ccnt_o = ccnt;
`endif

endmodule

// File: tb/tb_mini_rf_wr_arbiter.sv
// tb_mini_rf_wr_arbiter: directed vectors against hand-computed grants and register-file writes.
module tb_mini_rf_wr_arbiter;
    import mini_cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze_i;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*DW-1:0] data_i;
    logic [NREQ-1:0]   gnt_o;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              busy_o;
    logic [DW-1:0]     rf [4];
    int                pass = 0;
    int                total = 0;
`ifdef MINI_RF_ARB_PERF_EN
    logic [NREQ*CW-1:0] gcnt_o;
    logic [CW-1:0]     ccnt_o;
`endif

    always #5 clk = ~clk;

    mini_rf_wr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .freeze_i (freeze_i),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .gnt_o    (gnt_o),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
`ifdef MINI_RF_ARB_PERF_EN
        .gcnt_o   (gcnt_o),
        .ccnt_o   (ccnt_o),
`endif
        .busy_o   (busy_o)
    );

    always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = '0;
        rst = 1'b1; freeze_i = 1'b0; req_i = '0; addr_i = '0; data_i = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_we", 32'(rf_we), 0);
        check("rst_waddr", 32'(rf_waddr), 0);
        check("rst_wdata", 32'(rf_wdata), 0);
        req_i = 3'b111;
        #1;
        check("rst_gnt_req", 32'(gnt_o), 0);
        check("rst_busy", 32'(busy_o), 1);
        req_i = '0;
        rst = 1'b0;

        // single request
        req_i = 3'b001; addr_i[0 +: AW] = 2'd2; data_i[0 +: DW] = 8'hA5;
        #1;
        check("single_gnt", 32'(gnt_o), 32'b001);
        check("single_busy", 32'(busy_o), 0);
        tick();
        req_i = '0;
        check("single_we", 32'(rf_we), 1);
        check("single_waddr", 32'(rf_waddr), 2);
        check("single_wdata", 32'(rf_wdata), 8'hA5);
        tick();
        check("single_we_off", 32'(rf_we), 0);
        check("single_r2", 32'(rf[2]), 8'hA5);

        // full contention from ptr=0
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            addr_i[i*AW +: AW] = AW'(i);
            data_i[i*DW +: DW] = DW'(8'h10 + i);
        end
        req_i = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rr_gnt", 32'(gnt_o), 32'(1 << (c % 3)));
            check("rr_busy", 32'(busy_o), 1);
            tick();
            check("rr_we", 32'(rf_we), 1);
            check("rr_waddr", 32'(rf_waddr), 32'(c % 3));
            check("rr_wdata", 32'(rf_wdata), 32'(8'h10 + c % 3));
        end
        req_i = '0;

        // freeze stall, ptr=0
        req_i = 3'b010; freeze_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("frz_gnt", 32'(gnt_o), 0);
            check("frz_busy", 32'(busy_o), 1);
            tick();
            check("frz_we", 32'(rf_we), 0);
        end
        freeze_i = 1'b0;
        #1;
        check("unfrz_gnt", 32'(gnt_o), 32'b010);
        tick();
        check("unfrz_waddr", 32'(rf_waddr), 1);
        // ptr is now 2 and must survive a freeze with full contention
        req_i = 3'b111; freeze_i = 1'b1;
        tick();
        tick();
        freeze_i = 1'b0;
        #1;
        check("frz_ptr_hold", 32'(gnt_o), 32'b100);
        tick();
        req_i = '0;

        // same-address race, ptr=0
        addr_i[0 +: AW] = 2'd1; data_i[0 +: DW] = 8'h11;
        addr_i[2*AW +: AW] = 2'd1; data_i[2*DW +: DW] = 8'h22;
        req_i = 3'b101;
        #1;
        check("race_gnt0", 32'(gnt_o), 32'b001);
        tick();
        req_i = 3'b100;
        check("race_w0", 32'(rf_wdata), 8'h11);
        check("race_a0", 32'(rf_waddr), 1);
        #1;
        check("race_gnt2", 32'(gnt_o), 32'b100);
        tick();
        req_i = '0;
        check("race_w2", 32'(rf_wdata), 8'h22);
        tick();
        check("race_r1", 32'(rf[1]), 8'h22);

        // reset after a grant to requester 2
        req_i = 3'b100;
        tick();
        req_i = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_we", 32'(rf_we), 0);
        check("rst2_waddr", 32'(rf_waddr), 0);
        check("rst2_wdata", 32'(rf_wdata), 0);
        // reset after a grant to requester 1 must pull ptr back from 2 to 0
        addr_i[AW +: AW] = 2'd3; data_i[DW +: DW] = 8'h5A;
        req_i = 3'b010;
        tick();
        req_i = 3'b111;
        rst = 1'b1;
        #1;
        check("rst1_gnt", 32'(gnt_o), 0);
        check("rst1_busy", 32'(busy_o), 1);
        tick();
        rst = 1'b0;
        check("rst1_we", 32'(rf_we), 0);
        check("rst1_waddr", 32'(rf_waddr), 0);
        #1;
        check("rst1_ptr0", 32'(gnt_o), 32'b001);
        tick();
        req_i = '0;
        check("rst1_wdata", 32'(rf_wdata), 8'h11);

`ifdef MINI_RF_ARB_PERF_EN
        do_reset();
        check("cnt_clr", 32'(ccnt_o), 0);
        req_i = 3'b011;
        for (int c = 0; c < 300; c++) tick();
        req_i = '0;
        check("gcnt0", 32'(gcnt_o[0 +: CW]), 150);
        check("gcnt1", 32'(gcnt_o[CW +: CW]), 150);
        check("gcnt2", 32'(gcnt_o[2*CW +: CW]), 0);
        check("ccnt_sat", 32'(ccnt_o), 8'hFF);
`endif

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/mini_rf_wr_arbiter.md
# mini_rf_wr_arbiter

Round-robin arbiter that shares the register file's single write port among NREQ requesters (ALU writeback, load return, debug port). It sits between the requesters and the register file. Each cycle it grants at most one request and drives a registered write strobe, address and data into the register file one cycle later. A freeze input lets the CPU controller stall all writeback without dropping requests.

## Interface
- NREQ, 3: number of write requesters; index 0 = ALU, 1 = load, 2 = debug.
- AW, 2: register address width (4 registers).
- DW, 8: register data width.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze_i  in  1  when high, no grant is issued this cycle.
- req_i  in  NREQ  per-requester write request; held until granted.
- addr_i  in  NREQ*AW  packed target addresses; requester i occupies bits [i*AW +: AW].
- data_i  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- gnt_o  out  NREQ  combinational one-hot grant; a request completes on the edge where req_i[i] && gnt_o[i].
- rf_we  out  1  registered write enable to the register file.
- rf_waddr  out  AW  registered write address.
- rf_wdata  out  DW  registered write data.
- busy_o  out  1  combinational; high when any req_i bit is high and not granted this cycle.

## Operation
- The round-robin pointer ptr holds the index of the highest-priority requester. The search order is ptr, ptr+1, …, wrapping modulo NREQ.
- gnt_o is one-hot to the first requester in search order with req_i high. gnt_o is all-zero if freeze_i is high, if rst is high, or if no request is pending.
- On an edge with a grant to requester k:
  - ptr <= (k+1) mod NREQ.
  - rf_we <= 1, rf_waddr <= addr_i[k], rf_wdata <= data_i[k].
- On an edge with no grant: rf_we <= 0, and ptr holds its value. rf_waddr and rf_wdata also hold their values; they are don't-care while rf_we is 0.
- Several requesters targeting the same address are serialised in round-robin order. The last one granted determines the final register value. No coalescing is performed.
- A requester may change addr_i/data_i only on a cycle where it is not requesting, or on the edge after its grant.
- freeze_i does not affect the pointer. Requests stay pending and busy_o reflects them.
- Reset (rst sampled high on an edge), whether idle or mid-stream:
  - ptr <= 0, rf_we <= 0, rf_waddr <= 0, rf_wdata <= 0.
  - Any in-flight write that has not yet reached the register file is discarded.

## Timing
- Grant latency: a request presented in cycle N with no contention and freeze_i low is granted in cycle N (gnt_o is combinational).
- Register-file write latency: rf_we is high in cycle N+1, and the register file captures the data at the end of cycle N+1.
- Sustained throughput: one write per cycle.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once every NREQ cycles. Worst-case wait is NREQ-1 cycles, not counting freeze cycles.
- Reset values: gnt_o = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy_o follows req_i.

## Configuration
- MINI_RF_ARB_PERF_EN defined:
  - Adds output gcnt_o (NREQ*8): per-requester saturating grant counters.
  - Adds output ccnt_o (8): a saturating count of cycles with two or more req_i bits high.
  - Both counters clear on rst and saturate at 8'hFF.
- MINI_RF_ARB_PERF_EN undefined: neither port exists and the counters are not built. Arbitration behaviour is identical in both builds.

## Structure
- Shared package mini_cpu_pkg contains:
  - Constants NREQ, AW, DW.
  - Requester indices REQ_ALU = 0, REQ_LD = 1, REQ_DBG = 2.
- Sub-module mini_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot gnt and a valid flag.
- The top level owns the ptr register, the output registers, freeze gating and the optional counters.

## Test plan
- Single request, no contention:
  - Stimulus: reset, then req_i=3'b001, addr=2'd2, data=8'hA5 for one cycle.
  - Response: gnt_o=3'b001 in the same cycle; next cycle rf_we=1, rf_waddr=2, rf_wdata=8'hA5; the register file reads r2=8'hA5 afterwards.
- Full contention for 6 cycles:
  - Stimulus: req_i=3'b111 held high.
  - Response: grant order 0,1,2,0,1,2; rf_we high for 6 consecutive cycles.
- Freeze stall:
  - Stimulus: req_i=3'b010, freeze_i=1 for 3 cycles, then freeze_i=0.
  - Response: gnt_o=0 and busy_o=1 during freeze; grant to requester 1 on the first unfrozen cycle; ptr unchanged during freeze.
- Same-address race:
  - Stimulus: requesters 0 and 2 both target address 1, with data 8'h11 and 8'h22, ptr=0.
  - Response: 8'h11 is written first, then 8'h22; final r1=8'h22.
- Reset mid-stream:
  - Stimulus: rst asserted on the edge after a grant to requester 2.
  - Response: rf_we=0 next cycle, the pending write is lost, and ptr=0, so requester 0 wins the next contention.
- Counters (with MINI_RF_ARB_PERF_EN):
  - Stimulus: 300 cycles of req_i=3'b011.
  - Response: gcnt for requesters 0 and 1 = 150 each; ccnt saturates at 8'hFF.
